// File: rtl/alarm_siren_ctrl_if.sv
// alarm_siren_ctrl_if: alarm input, operator ack and siren/lamp/status outputs
interface alarm_siren_ctrl_if;
    logic       alarm_in;
    logic       ack;
    logic       siren;
    logic       lamp;
    logic [1:0] state;
    logic [7:0] event_count;
    modport master (output alarm_in, ack, input siren, lamp, state, event_count);
    modport slave (input alarm_in, ack, output siren, lamp, state, event_count);
endinterface

// File: rtl/alarm_siren_ctrl.sv
// alarm_siren_ctrl: synchronized, debounced alarm latch driving a blinking siren and a steady lamp
module alarm_siren_ctrl #(
    parameter int DEBOUNCE_CYC  = 4,
    parameter int SIREN_HALF    = 8,
    parameter int SIREN_TIMEOUT = 64
) (
    input logic clk,
    input logic reset,
    alarm_siren_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(SIREN_HALF + 1);
    localparam int TW = $clog2(SIREN_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, PENDING = 2'b01, ALARM = 2'b10, SILENCED = 2'b11} state_t;
    state_t        state, state_nxt;
    logic          s1, alarm_s;
    logic [DW-1:0] cnt, cnt_nxt;
    logic [HW-1:0] half, half_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic          siren, siren_nxt, lamp, lamp_nxt;
    logic [7:0]    events, events_nxt;
    logic          confirm;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            s1      <= 1'b0;
            alarm_s <= 1'b0;
            cnt     <= '0;
            half    <= '0;
            tmo     <= '0;
            siren   <= 1'b0;
            lamp    <= 1'b0;
            events  <= '0;
        end else begin
            state   <= state_nxt;
            s1      <= bus.alarm_in;
            alarm_s <= s1;
            cnt     <= cnt_nxt;
            half    <= half_nxt;
            tmo     <= tmo_nxt;
            siren   <= siren_nxt;
            lamp    <= lamp_nxt;
            events  <= events_nxt;
        end
    // cnt is the debounce run in PENDING and the release run in SILENCED
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        half_nxt   = half;
        tmo_nxt    = tmo;
        siren_nxt  = siren;
        lamp_nxt   = lamp;
        events_nxt = events;
        confirm    = alarm_s && ((state == IDLE && DEBOUNCE_CYC == 1) ||
                                 (state == PENDING && cnt == DW'(DEBOUNCE_CYC - 1)));
        case (state)
            IDLE: if (alarm_s) begin
                state_nxt = PENDING;
                cnt_nxt   = DW'(1);
            end
            PENDING: begin
                state_nxt = alarm_s ? PENDING : IDLE;
                cnt_nxt   = alarm_s ? cnt + 1'b1 : '0;
            end
            ALARM: begin
                half_nxt  = half == HW'(SIREN_HALF - 1) ? '0 : half + 1'b1;
                siren_nxt = half == HW'(SIREN_HALF - 1) ? ~siren : siren;
                tmo_nxt   = tmo + 1'b1;
                if (bus.ack || tmo == TW'(SIREN_TIMEOUT - 1)) begin
                    state_nxt = SILENCED;
                    siren_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                cnt_nxt = alarm_s ? '0 : cnt + 1'b1;
                if (!alarm_s && cnt == DW'(DEBOUNCE_CYC - 1)) begin
                    state_nxt = IDLE;
                    lamp_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end
            end
        endcase
        if (confirm) begin
            state_nxt  = ALARM;
            cnt_nxt    = '0;
            half_nxt   = '0;
            tmo_nxt    = '0;
            siren_nxt  = 1'b1;
            lamp_nxt   = 1'b1;
            events_nxt = events == 8'hff ? events : events + 8'd1;
        end
    end
    assign bus.state       = state;
    assign bus.siren       = siren;
    assign bus.lamp        = lamp;
    assign bus.event_count = events;
endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// tb_alarm_siren_ctrl: directed and random stimulus against an edge-count reference model
module tb_alarm_siren_ctrl;
    localparam int D = 4;
    localparam int H = 8;
    localparam int T = 64;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    int m_mode, m_run, m_low, m_e, m_ev, m_s1, m_s2, ecount;
    alarm_siren_ctrl_if bus();
    alarm_siren_ctrl #(.DEBOUNCE_CYC(D), .SIREN_HALF(H), .SIREN_TIMEOUT(T)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, ecount);
        end
    endtask
    task automatic model_reset;
        m_mode = 0; m_run = 0; m_low = 0; m_e = 0; m_ev = 0; m_s1 = 0; m_s2 = 0;
    endtask
    // alarm_s seen at an edge is alarm_in as sampled two edges earlier
    task automatic model_edge(input int a, input int k);
        int a_s = m_s2;
        m_s2 = m_s1;
        m_s1 = a;
        ecount++;
        case (m_mode)
            0, 1: if (a_s != 0) begin
                m_run++;
                if (m_run == D) begin
                    m_mode = 2; m_e = ecount; m_run = 0;
                    m_ev = m_ev < 255 ? m_ev + 1 : 255;
                end else m_mode = 1;
            end else begin
                m_run = 0; m_mode = 0;
            end
            2: if (k != 0 || ecount - m_e == T) begin
                m_mode = 3; m_low = 0;
            end
            default: begin
                m_low = a_s != 0 ? 0 : m_low + 1;
                if (m_low == D) begin
                    m_mode = 0; m_run = 0;
                end
            end
        endcase
    endtask
    task automatic check_all;
        chk("state", int'(bus.state), m_mode);
        chk("siren", int'(bus.siren), (m_mode == 2 && ((ecount - m_e) / H) % 2 == 0) ? 1 : 0);
        chk("lamp", int'(bus.lamp), m_mode >= 2 ? 1 : 0);
        chk("event_count", int'(bus.event_count), m_ev);
    endtask
    task automatic step(input int a, input int k);
        bus.alarm_in = a[0];
        bus.ack = k[0];
        @(posedge clk);
        model_edge(a, k);
        @(negedge clk);
        check_all();
    endtask
    // reset asserted between edges must clear outputs before any edge
    task automatic do_reset;
        #1 reset = 1'b1;
        #1;
        chk("rst_state", int'(bus.state), 0);
        chk("rst_siren", int'(bus.siren), 0);
        chk("rst_lamp", int'(bus.lamp), 0);
        chk("rst_events", int'(bus.event_count), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask
    initial begin
        int lvl;
        bus.alarm_in = 1'b0;
        bus.ack = 1'b0;
        ecount = -1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("init_state", int'(bus.state), 0);
        chk("init_events", int'(bus.event_count), 0);
        check_all();
        for (int i = 0; i < 8; i++) begin
            step(1, 0);
            if (i == 2) chk("pend_latency", int'(bus.state), 1);
            if (i == 5) begin
                chk("alarm_latency", int'(bus.state), 2);
                chk("alarm_siren", int'(bus.siren), 1);
                chk("first_event", int'(bus.event_count), 1);
            end
        end
        repeat (80) step(0, 0);
        chk("timeout_release", int'(bus.state), 0);
        repeat (3) step(1, 0);
        repeat (8) step(0, 0);
        chk("glitch_events", int'(bus.event_count), 1);
        repeat (16) step(1, 0);
        step(1, 1);
        chk("ack_state", int'(bus.state), 3);
        step(1, 1);
        for (int i = 0; i < 30; i++) step(i % 3 == 0 ? 1 : 0, 0);
        chk("toggle_hold", int'(bus.state), 3);
        repeat (8) step(0, 0);
        repeat (260) begin
            repeat (6) step(1, 0);
            step(0, 1);
            repeat (7) step(0, 0);
        end
        chk("saturate", int'(bus.event_count), 255);
        repeat (6) step(1, 0);
        do_reset();
        lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) lvl = 1 - lvl;
            step(lvl, $urandom_range(0, 19) == 0 ? 1 : 0);
            if ($urandom_range(0, 399) == 0) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
